// File: rtl/urv_timer_cmp.sv
// -----------------------------------------------------------------------------
// urv_timer_cmp
//   Free-running cycle counter, prescaled tick counter with a writable time
//   base, and g_num_compare sticky/maskable compare interrupts behind a small
//   32-bit register port.
//
// Ports
//   clk_i          system clock
//   rst_n_i        synchronous reset, active low
//   addr_i         byte address, bits [1:0] ignored
//   data_i         write data
//   we_i / re_i    single-cycle write / read strobes
//   data_o         read data, valid the cycle after re_i, held otherwise
//   csr_time_o     current tick count
//   csr_cycles_o   free-running cycle count
//   sys_tick_o     one-cycle pulse per tick
//   irq_o          registered OR of (pending & mask)
//
// Register map (word index = addr_i[5:2])
//   0x00 CTRL (bit0 enable)   0x04 TIME_LO   0x08 TIME_HI
//   0x0C PENDING (W1C)        0x10 MASK
//   0x20+8n CMPn_LO           0x24+8n CMPn_HI
// -----------------------------------------------------------------------------
module urv_timer_cmp #(
    parameter int unsigned g_width           = 64,
    parameter int unsigned g_num_compare     = 2,
    parameter int unsigned g_clock_frequency = 62500000,
    parameter int unsigned g_timer_frequency = 1000
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [5:0]         addr_i,
    input  logic [31:0]        data_i,
    input  logic               we_i,
    input  logic               re_i,
    output logic [31:0]        data_o,
    output logic [g_width-1:0] csr_time_o,
    output logic [g_width-1:0] csr_cycles_o,
    output logic               sys_tick_o,
    output logic               irq_o
);

    localparam int unsigned C_DIV      = g_clock_frequency / g_timer_frequency;
    localparam int unsigned C_PW       = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam int unsigned C_HW       = g_width - 32;
    localparam int unsigned C_NC       = g_num_compare;
    localparam int unsigned C_CMP_WORD = 8;

    localparam logic [C_PW-1:0] C_PRESC_MAX = C_PW'(C_DIV - 1);

    localparam logic [3:0] A_CTRL    = 4'h0;
    localparam logic [3:0] A_TIME_LO = 4'h1;
    localparam logic [3:0] A_TIME_HI = 4'h2;
    localparam logic [3:0] A_PENDING = 4'h3;
    localparam logic [3:0] A_MASK    = 4'h4;

    // Reject parameter sets outside the supported range at elaboration.
    if (g_width < 33 || g_width > 64) begin : g_bad_width
        $error("urv_timer_cmp: g_width must be in 33..64");
    end
    if (g_num_compare < 1 || g_num_compare > 4) begin : g_bad_ncmp
        $error("urv_timer_cmp: g_num_compare must be in 1..4");
    end
    if (C_DIV < 1) begin : g_bad_div
        $error("urv_timer_cmp: clock/timer frequency ratio must be >= 1");
    end

    logic [C_PW-1:0]    presc_q,   presc_d;
    logic               tick_q,    tick_d;
    logic [g_width-1:0] time_q,    time_d;
    logic [g_width-1:0] cycles_q,  cycles_d;
    logic               enable_q,  enable_d;
    logic [g_width-1:0] cmp_q [C_NC];
    logic [g_width-1:0] cmp_d [C_NC];
    logic [C_NC-1:0]    pending_q, pending_d;
    logic [C_NC-1:0]    mask_q,    mask_d;
    logic [C_HW-1:0]    shadow_q,  shadow_d;
    logic [31:0]        data_q,    data_d;
    logic               irq_q,     irq_d;

    logic [3:0]         word;
    logic               unused_addr;

    assign word        = addr_i[5:2];
    assign unused_addr = ^addr_i[1:0];

    // Next-state logic for counters, register writes, compares and reads.
    always_comb begin
        presc_d   = presc_q;
        tick_d    = 1'b0;
        time_d    = time_q;
        cycles_d  = cycles_q + g_width'(1);
        enable_d  = enable_q;
        cmp_d     = cmp_q;
        pending_d = pending_q;
        mask_d    = mask_q;
        shadow_d  = shadow_q;
        data_d    = data_q;
        irq_d     = |(pending_q & mask_q);

        // Prescaler only runs while enabled; time advances on the same edge
        // that raises sys_tick_o.
        if (enable_q) begin
            if (presc_q == C_PRESC_MAX) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + C_PW'(1);
            end
        end
        if (tick_d) begin
            time_d = time_q + g_width'(1);
        end

        // A time write replaces the whole next value, so a coincident tick is lost.
        if (we_i) begin
            case (word)
                A_CTRL:    enable_d = data_i[0];
                A_TIME_LO: time_d   = {time_q[g_width-1:32], data_i};
                A_TIME_HI: time_d   = {data_i[C_HW-1:0], time_q[31:0]};
                A_PENDING: pending_d = pending_q & ~data_i[C_NC-1:0];
                A_MASK:    mask_d   = data_i[C_NC-1:0];
                default: ;
            endcase
            for (int n = 0; n < int'(C_NC); n++) begin
                if (word == 4'(C_CMP_WORD + 2 * n)) begin
                    cmp_d[n][31:0] = data_i;
                end
                if (word == 4'(C_CMP_WORD + 2 * n + 1)) begin
                    cmp_d[n][g_width-1:32] = data_i[C_HW-1:0];
                end
            end
        end

        // Compare sets after the W1C clear so that set wins a same-cycle race.
        for (int n = 0; n < int'(C_NC); n++) begin
            if (time_q >= cmp_q[n]) begin
                pending_d[n] = 1'b1;
            end
        end

        // Reads see pre-write state; a TIME_LO read snapshots the upper half.
        if (re_i) begin
            data_d = '0;
            case (word)
                A_CTRL:    data_d = {31'b0, enable_q};
                A_TIME_LO: begin
                    data_d   = time_q[31:0];
                    shadow_d = time_q[g_width-1:32];
                end
                A_TIME_HI: data_d = 32'(shadow_q);
                A_PENDING: data_d = 32'(pending_q);
                A_MASK:    data_d = 32'(mask_q);
                default: ;
            endcase
            for (int n = 0; n < int'(C_NC); n++) begin
                if (word == 4'(C_CMP_WORD + 2 * n)) begin
                    data_d = cmp_q[n][31:0];
                end
                if (word == 4'(C_CMP_WORD + 2 * n + 1)) begin
                    data_d = 32'(cmp_q[n][g_width-1:32]);
                end
            end
        end
    end

    // State registers; reset discards any access in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            presc_q   <= '0;
            tick_q    <= 1'b0;
            time_q    <= '0;
            cycles_q  <= '0;
            enable_q  <= 1'b1;
            for (int n = 0; n < int'(C_NC); n++) begin
                cmp_q[n] <= '1;
            end
            pending_q <= '0;
            mask_q    <= '0;
            shadow_q  <= '0;
            data_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            time_q    <= time_d;
            cycles_q  <= cycles_d;
            enable_q  <= enable_d;
            cmp_q     <= cmp_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            irq_q     <= irq_d;
        end
    end

    assign data_o       = data_q;
    assign csr_time_o   = time_q;
    assign csr_cycles_o = cycles_q;
    assign sys_tick_o   = tick_q;
    assign irq_o        = irq_q;

endmodule
